// File: rtl/c_drain_sequencer_pkg.sv
// Shared definitions for the C-buffer drain sequencer: FSM encoding,
// requantization constants and the int8 saturation helper.
package c_drain_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Q31 encoding of 0.5, the usual "halve the accumulator" multiplier.
    localparam logic [31:0] Q31_HALF = 32'h4000_0000;

    // Output saturation limits, widened to the width of the offset sum.
    localparam logic signed [33:0] INT8_MAX_W = 34'sd127;
    localparam logic signed [33:0] INT8_MIN_W = -34'sd128;

    // Saturate a wide signed value to int8 and return its two's complement byte.
    function automatic logic [7:0] clamp_int8(input logic signed [33:0] v);
        logic [7:0] res;
        if (v > INT8_MAX_W) begin
            res = 8'h7F;
        end else if (v < INT8_MIN_W) begin
            res = 8'h80;
        end else begin
            res = v[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/c_drain_sequencer_requant_lane.sv
// One int32 -> int8 requantization lane, two register stages.
// Stage 1: bias add (wrapping) and signed Q31 multiply, keeping p[62:31].
// Stage 2: rounding right shift (ties away from zero), offset, int8 clamp.
// The lane free-runs; the parent tracks which stage contents are valid.
module c_drain_sequencer_requant_lane
    import c_drain_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_acc,
    input  logic [31:0] i_bias,
    input  logic [31:0] i_mult,
    input  logic [4:0]  i_shift,
    input  logic [31:0] i_offset,
    output logic [7:0]  o_q
);

    logic [31:0] w_sum;
    logic [63:0] w_prod;
    logic        w_unused_prod;
    logic [31:0] r_x;
    logic [31:0] w_shifted;
    logic [4:0]  w_sh_m1;
    logic [31:0] w_mask;
    logic        w_round;
    logic [31:0] w_y;
    logic [33:0] w_z;
    logic [7:0]  r_q;

    // Sign-extend both operands to 64 bits so the low 64 product bits are the signed product.
    assign w_sum         = i_acc + i_bias;
    assign w_prod        = {{32{w_sum[31]}}, w_sum} * {{32{i_mult[31]}}, i_mult};
    assign w_unused_prod = ^{w_prod[63], w_prod[30:0]};

    // Stage 1 register: only the Q31-aligned slice is ever consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
        end else begin
            r_x <= w_prod[62:31];
        end
    end

    // Round half away from zero: the half bit always rounds up magnitude for
    // positives; negatives need a set sticky bit below the half bit as well.
    assign w_shifted = $unsigned($signed(r_x) >>> i_shift);
    assign w_sh_m1   = i_shift - 5'd1;
    assign w_mask    = (32'd1 << w_sh_m1) - 32'd1;
    assign w_round   = (i_shift != 5'd0) && r_x[w_sh_m1] &&
                       (!r_x[31] || (|(r_x & w_mask)));
    assign w_y       = w_shifted + {31'd0, w_round};
    assign w_z       = {{2{w_y[31]}}, w_y} + {{2{i_offset[31]}}, i_offset};

    // Stage 2 register: saturated int8 result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= clamp_int8($signed(w_z));
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/c_drain_sequencer.sv
// Burst drain of the 128-bit accumulator buffer: issues consecutive reads,
// requantizes the four int32 lanes of each word to int8, packs them into a
// 32-bit word and queues it in a small output FIFO. Reads are only issued
// when the FIFO plus the requant pipeline can absorb the result, so the FIFO
// never overflows regardless of the consumer's ready pattern.
module c_drain_sequencer
    import c_drain_sequencer_pkg::*;
#(
    parameter int C_BITS     = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    input  logic [31:0]       cfg_bias,
    input  logic [31:0]       cfg_mult,
    input  logic [4:0]        cfg_shift,
    input  logic [31:0]       cfg_offset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [C_BITS-1:0] start_base,
    input  logic [C_BITS:0]   start_count,
    input  logic              tpu_busy,
    output logic              c_rd_en,
    output logic [C_BITS-1:0] c_index,
    input  logic [127:0]      c_data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW+1:0]   DEPTH_W = (CW + 2)'(FIFO_DEPTH);
    localparam logic [AW-1:0]   PTR_ONE = AW'(1);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [C_BITS:0] REM_ONE = (C_BITS + 1)'(1);
    localparam logic [C_BITS-1:0] IDX_ONE = C_BITS'(1);

    state_t              r_state;
    logic [C_BITS-1:0]   r_base;
    logic [C_BITS-1:0]   r_issued;
    logic [C_BITS:0]     r_remaining;
    logic                r_done;
    logic [31:0]         r_cfg_bias;
    logic [31:0]         r_cfg_mult;
    logic [4:0]          r_cfg_shift;
    logic [31:0]         r_cfg_offset;

    // Per-stage valid / last tags travelling alongside the requant lanes.
    logic                r_v0, r_v1, r_v2;
    logic                r_l0, r_l1, r_l2;

    logic [32:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;

    logic [3:0][7:0]     w_q;
    logic [32:0]         w_head;
    logic                w_push;
    logic                w_pop;
    logic [1:0]          w_inflight;
    logic [CW+1:0]       w_used;
    logic [CW+1:0]       w_limit;
    logic                w_issue;

    // Lane 0 is the most significant 32 bits of the C word and lands in the output LSB byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            c_drain_sequencer_requant_lane u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_acc    (c_data_out[127 - 32*gi -: 32]),
                .i_bias   (r_cfg_bias),
                .i_mult   (r_cfg_mult),
                .i_shift  (r_cfg_shift),
                .i_offset (r_cfg_offset),
                .o_q      (w_q[gi])
            );
        end
    endgenerate

    // A word popped this cycle frees its slot at the same edge, so it counts as
    // credit; this keeps one word per cycle sustainable with a 4-entry FIFO.
    assign w_push     = r_v2;
    assign w_pop      = (r_count != '0) && out_ready;
    assign w_inflight = {1'b0, r_v0} + {1'b0, r_v1} + {1'b0, r_v2};
    assign w_used     = {2'b00, r_count} + {{CW{1'b0}}, w_inflight};
    assign w_limit    = DEPTH_W + {{(CW+1){1'b0}}, w_pop};
    assign w_issue    = (r_state == ST_RUN) && !tpu_busy &&
                        (r_remaining != '0) && (w_used < w_limit);

    assign c_rd_en     = w_issue;
    assign c_index     = r_base + r_issued;
    assign w_head      = r_mem[r_rd_ptr];
    assign out_valid   = (r_count != '0);
    assign out_data    = out_valid ? w_head[31:0] : 32'd0;
    assign out_last    = out_valid && w_head[32];
    assign start_ready = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;

    // Control FSM: accepts config and drain requests while idle, counts issued reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_base       <= '0;
            r_issued     <= '0;
            r_remaining  <= '0;
            r_done       <= 1'b0;
            r_cfg_bias   <= '0;
            r_cfg_mult   <= '0;
            r_cfg_shift  <= '0;
            r_cfg_offset <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        r_cfg_bias   <= cfg_bias;
                        r_cfg_mult   <= cfg_mult;
                        r_cfg_shift  <= cfg_shift;
                        r_cfg_offset <= cfg_offset;
                    end
                    if (start_valid) begin
                        if (start_count != '0) begin
                            r_state     <= ST_RUN;
                            r_base      <= start_base;
                            r_remaining <= start_count;
                            r_issued    <= '0;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        r_remaining <= r_remaining - REM_ONE;
                        r_issued    <= r_issued + IDX_ONE;
                        if (r_remaining == REM_ONE) begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_pop && w_head[32]) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Valid/last tags follow each read through data return and both lane stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_l0 <= 1'b0;
            r_l1 <= 1'b0;
            r_l2 <= 1'b0;
        end else begin
            r_v0 <= w_issue;
            r_l0 <= w_issue && (r_remaining == REM_ONE);
            r_v1 <= r_v0;
            r_l1 <= r_l0;
            r_v2 <= r_v1;
            r_l2 <= r_l1;
        end
    end

    // FIFO storage; contents need no reset because out_data is masked when empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_l2, w_q};
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
